// File: rtl/trace_capture_pkg.sv
// rtl/trace_capture_pkg.sv - shared scope definitions: acquisition states, trace geometry, row mapping
package trace_capture_pkg;

  localparam int DEPTH_DEF    = 640;
  localparam int TIMEOUT_DEF  = 65535;
  localparam int Y_OFFSET_DEF = 431;
  localparam int INDEX_W      = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } scopeState_t;

  // Larger ADC values sit higher on screen, i.e. at smaller row numbers.
  function automatic logic [8:0] toRow(input logic [8:0] yOffset, input logic [7:0] s);
    return yOffset - {1'b0, s};
  endfunction

endpackage

// File: rtl/trace_capture_trig_detect.sv
// rtl/trace_capture_trig_detect.sv - slope trigger: previous-sample register and first-sample guard
module trig_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] sample,
  input  logic [7:0] trigLevel,
  input  logic       trigRising,
  output logic       hit
);

  logic [7:0] prev;
  logic       primed;

  // primed drops whenever we leave ARMED so the first sample of a new arming only seeds prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      primed <= 1'b0;
    end else if (clear) begin
      primed <= 1'b0;
    end else if (accept) begin
      prev   <= sample;
      primed <= 1'b1;
    end
  end

  assign hit = primed && (trigRising ? (prev < trigLevel && sample >= trigLevel)
                                     : (prev > trigLevel && sample <= trigLevel));

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - oscilloscope trace acquisition into a double-buffered trace RAM
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int Y_OFFSET = Y_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [7:0]  sample,
  input  logic [7:0]  trig_level,
  input  logic        trig_rising,
  input  logic        run,
  input  logic        auto_trig,
  input  logic        vsync,
  output logic        ram_we,
  output logic [10:0] ram_waddr,
  output logic [8:0]  ram_wdata,
  output logic        rd_bank,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  scopeState_t          state, nextState;
  logic [INDEX_W-1:0]   index;
  logic [CNT_W-1:0]     toCount;
  logic                 vsyncQ;
  logic                 vsyncEdge;
  logic                 trigHit;
  logic                 timedOut;
  logic                 doWrite;
  logic                 lastIndex;

  assign vsyncEdge = vsync && !vsyncQ;
  assign timedOut  = auto_trig && (toCount == CNT_W'(TIMEOUT));
  assign lastIndex = (index == INDEX_W'(DEPTH - 1));
  assign busy      = (state != IDLE);

  trig_detect uTrig (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state != ARMED),
    .accept     (sample_valid && state == ARMED),
    .sample     (sample),
    .trigLevel  (trig_level),
    .trigRising (trig_rising),
    .hit        (trigHit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    doWrite   = 1'b0;
    case (state)
      IDLE: begin
        if (run) nextState = ARMED;
      end
      ARMED: begin
        if (!run) begin
          nextState = IDLE;
        end else if (sample_valid && (trigHit || timedOut)) begin
          doWrite   = 1'b1;
          nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        // run is deliberately ignored here: a started trace always completes.
        if (sample_valid) begin
          doWrite = 1'b1;
          if (lastIndex) nextState = DONE;
        end
      end
      DONE: begin
        if (vsyncEdge) nextState = run ? ARMED : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // index is always 0 while ARMED, so the triggering sample lands at index 0 without special casing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsyncQ    <= 1'b0;
      rd_bank   <= 1'b0;
      index     <= '0;
      toCount   <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      vsyncQ <= vsync;
      ram_we <= doWrite;
      if (doWrite) begin
        ram_waddr <= {~rd_bank, index};
        ram_wdata <= toRow(9'(Y_OFFSET), sample);
        index     <= lastIndex ? '0 : index + INDEX_W'(1);
      end
      if (state != ARMED) begin
        toCount <= '0;
      end else if (sample_valid && !timedOut && toCount != CNT_W'(TIMEOUT)) begin
        toCount <= toCount + CNT_W'(1);
      end
      // Only a finished trace may be handed to the display, and only at frame start.
      if (state == DONE && vsyncEdge) rd_bank <= ~rd_bank;
    end
  end

endmodule
